// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared constants and types for the single-port SRAM arbiter
// Contents:
//   ADDR_W, DATA_W, BEN_W, NUM_PORTS : macro geometry and requester count
//   BEN_IDLE                         : active-low byte-enable value that masks every byte
//   acc_e                            : access type carried by a granted request
package sram_arb_pkg;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int BEN_W     = DATA_W / 8;
  localparam int NUM_PORTS = 2;

  localparam logic [BEN_W-1:0] BEN_IDLE = '1;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_e;

endpackage

// File: rtl/sram_arb_rsp_slot.sv
// rtl/sram_arb_rsp_slot.sv - per-port read response slot (in-flight flag + one-entry buffer)
// Ports:
//   clk, rstn   : clock, synchronous active-low reset
//   rd_accept   : a read from this port is accepted on the current edge
//   rsp_ready   : requester consumes the presented response
//   sram_q      : macro read data, valid in the cycle after the accepting edge
//   slot_free   : a new read may be accepted this cycle
//   rsp_valid   : response presented to the requester
//   rsp_rdata   : response data (buffer first, then live macro data)
module sram_arb_rsp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rd_accept,
  input  logic              rsp_ready,
  input  logic [DATA_W-1:0] sram_q,
  output logic              slot_free,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  logic              inflight_q, inflight_d;
  logic              full_q, full_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  always_comb begin
    inflight_d = rd_accept;
    full_d     = full_q;
    buf_d      = buf_q;
    if (full_q) begin
      if (rsp_ready) begin
        full_d = 1'b0;
      end
    end else if (inflight_q && !rsp_ready) begin
      // Macro output is only valid for one cycle; park it until consumed.
      full_d = 1'b1;
      buf_d  = sram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inflight_q <= 1'b0;
      full_q     <= 1'b0;
      buf_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      full_q     <= full_d;
      buf_q      <= buf_d;
    end
  end

  // A read may follow immediately if the current response leaves this cycle.
  assign slot_free = !full_q && (!inflight_q || rsp_ready);

  // Reset is synchronous, so the flags still hold old state during the
  // reset cycle; gate the outputs so no stale response escapes.
  assign rsp_valid = rstn && (full_q || inflight_q);

  always_comb begin
    rsp_rdata = '0;
    if (rstn) begin
      if (full_q) begin
        rsp_rdata = buf_q;
      end else if (inflight_q) begin
        rsp_rdata = sram_q;
      end
    end
  end

endmodule

// File: rtl/sram_sp_arbiter.sv
// rtl/sram_sp_arbiter.sv - two-port arbiter/sequencer for a single-port byte-enable SRAM macro
// Port 0 = instruction fetch, port 1 = data. One access per cycle to the macro.
// Option macro SRAM_ARB_RR_EN: defined = round-robin arbitration with a 1-bit
// preferred-port pointer; undefined = fixed priority, port 1 over port 0.
// Ports:
//   CLK, RSTn                    : clock, synchronous active-low reset
//   Pn_REQ_VALID/READY           : request handshake (READY combinational)
//   Pn_REQ_WRITE/ADDR/BE/WDATA   : request payload (BE active-high, writes only)
//   Pn_RSP_VALID/READY/RDATA     : read response handshake, one-cycle latency
//   SRAM_CEN/GWEN/BEN            : active-low macro controls
//   SRAM_A/D/Q                   : macro address, write data, read data
module sram_sp_arbiter #(
  parameter int ADDR_W = sram_arb_pkg::ADDR_W,
  parameter int DATA_W = sram_arb_pkg::DATA_W
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                P0_REQ_VALID,
  output logic                P0_REQ_READY,
  input  logic                P0_REQ_WRITE,
  input  logic [ADDR_W-1:0]   P0_REQ_ADDR,
  input  logic [DATA_W/8-1:0] P0_REQ_BE,
  input  logic [DATA_W-1:0]   P0_REQ_WDATA,
  output logic                P0_RSP_VALID,
  input  logic                P0_RSP_READY,
  output logic [DATA_W-1:0]   P0_RSP_RDATA,
  input  logic                P1_REQ_VALID,
  output logic                P1_REQ_READY,
  input  logic                P1_REQ_WRITE,
  input  logic [ADDR_W-1:0]   P1_REQ_ADDR,
  input  logic [DATA_W/8-1:0] P1_REQ_BE,
  input  logic [DATA_W-1:0]   P1_REQ_WDATA,
  output logic                P1_RSP_VALID,
  input  logic                P1_RSP_READY,
  output logic [DATA_W-1:0]   P1_RSP_RDATA,
  output logic                SRAM_CEN,
  output logic                SRAM_GWEN,
  output logic [DATA_W/8-1:0] SRAM_BEN,
  output logic [ADDR_W-1:0]   SRAM_A,
  output logic [DATA_W-1:0]   SRAM_D,
  input  logic [DATA_W-1:0]   SRAM_Q
);

  import sram_arb_pkg::*;

  localparam int BW = DATA_W / 8;

  logic slot_free0, slot_free1;
  logic elig0, elig1;
  logic gnt_vld, gnt_port;
  acc_e gnt_acc;

  // Writes bypass the slot check: they produce no response.
  assign elig0 = RSTn && P0_REQ_VALID && (P0_REQ_WRITE || slot_free0);
  assign elig1 = RSTn && P1_REQ_VALID && (P1_REQ_WRITE || slot_free1);

`ifdef SRAM_ARB_RR_EN
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_vld  = elig0 || elig1;
    gnt_port = elig1 && !elig0;
    ptr_d    = ptr_q;
    // Only contested grants move the pointer.
    if (elig0 && elig1) begin
      gnt_port = ptr_q;
      ptr_d    = ~ptr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt_vld  = elig0 || elig1;
    gnt_port = elig1;
  end
`endif

  assign P0_REQ_READY = gnt_vld && !gnt_port;
  assign P1_REQ_READY = gnt_vld && gnt_port;

  always_comb begin
    SRAM_CEN  = 1'b1;
    SRAM_GWEN = 1'b1;
    SRAM_BEN  = {BW{1'b1}};
    SRAM_A    = '0;
    SRAM_D    = '0;
    gnt_acc   = ACC_READ;
    if (gnt_vld) begin
      SRAM_CEN = 1'b0;
      if (gnt_port) begin
        gnt_acc = P1_REQ_WRITE ? ACC_WRITE : ACC_READ;
        SRAM_A  = P1_REQ_ADDR;
        if (gnt_acc == ACC_WRITE) begin
          SRAM_GWEN = 1'b0;
          SRAM_BEN  = ~P1_REQ_BE;
          SRAM_D    = P1_REQ_WDATA;
        end
      end else begin
        gnt_acc = P0_REQ_WRITE ? ACC_WRITE : ACC_READ;
        SRAM_A  = P0_REQ_ADDR;
        if (gnt_acc == ACC_WRITE) begin
          SRAM_GWEN = 1'b0;
          SRAM_BEN  = ~P0_REQ_BE;
          SRAM_D    = P0_REQ_WDATA;
        end
      end
    end
  end

  sram_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk       (CLK),
    .rstn      (RSTn),
    .rd_accept (P0_REQ_READY && !P0_REQ_WRITE),
    .rsp_ready (P0_RSP_READY),
    .sram_q    (SRAM_Q),
    .slot_free (slot_free0),
    .rsp_valid (P0_RSP_VALID),
    .rsp_rdata (P0_RSP_RDATA)
  );

  sram_arb_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk       (CLK),
    .rstn      (RSTn),
    .rd_accept (P1_REQ_READY && !P1_REQ_WRITE),
    .rsp_ready (P1_RSP_READY),
    .sram_q    (SRAM_Q),
    .slot_free (slot_free1),
    .rsp_valid (P1_RSP_VALID),
    .rsp_rdata (P1_RSP_RDATA)
  );

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// tb/tb_sram_sp_arbiter.sv - scoreboard bench for sram_sp_arbiter with a behavioural SRAM macro
module tb_sram_sp_arbiter;

  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        p0_req_valid, p0_req_ready, p0_req_write;
  logic [12:0] p0_req_addr;
  logic [3:0]  p0_req_be;
  logic [31:0] p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_ready;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_write;
  logic [12:0] p1_req_addr;
  logic [3:0]  p1_req_be;
  logic [31:0] p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_ready;
  logic [31:0] p1_rsp_rdata;
  logic        sram_cen, sram_gwen;
  logic [3:0]  sram_ben;
  logic [12:0] sram_a;
  logic [31:0] sram_d, sram_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:8191];
  logic [31:0] exp_mem [int];
  logic [31:0] sb_q0 [$];
  logic [31:0] sb_q1 [$];

  always #5 clk = ~clk;

  sram_sp_arbiter dut (
    .CLK(clk), .RSTn(rstn),
    .P0_REQ_VALID(p0_req_valid), .P0_REQ_READY(p0_req_ready), .P0_REQ_WRITE(p0_req_write),
    .P0_REQ_ADDR(p0_req_addr), .P0_REQ_BE(p0_req_be), .P0_REQ_WDATA(p0_req_wdata),
    .P0_RSP_VALID(p0_rsp_valid), .P0_RSP_READY(p0_rsp_ready), .P0_RSP_RDATA(p0_rsp_rdata),
    .P1_REQ_VALID(p1_req_valid), .P1_REQ_READY(p1_req_ready), .P1_REQ_WRITE(p1_req_write),
    .P1_REQ_ADDR(p1_req_addr), .P1_REQ_BE(p1_req_be), .P1_REQ_WDATA(p1_req_wdata),
    .P1_RSP_VALID(p1_rsp_valid), .P1_RSP_READY(p1_rsp_ready), .P1_RSP_RDATA(p1_rsp_rdata),
    .SRAM_CEN(sram_cen), .SRAM_GWEN(sram_gwen), .SRAM_BEN(sram_ben),
    .SRAM_A(sram_a), .SRAM_D(sram_d), .SRAM_Q(sram_q)
  );

  // Behavioural single-port macro: active-low controls, one-cycle read.
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < 4; b++) begin
          if (!sram_ben[b]) mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
        end
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [12:0] a);
    if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
    return 32'hXXXX_XXXX;
  endfunction

  // Scoreboard: pop on consumed responses, update reference / push on accepts.
  always @(negedge clk) begin
    if (rstn) begin
      if (p0_rsp_valid && p0_rsp_ready) begin
        if (sb_q0.size() == 0) chk("p0_rsp_unexpected", 32'd1, 32'd0);
        else chk("p0_rsp_data", p0_rsp_rdata, sb_q0.pop_front());
      end
      if (p1_rsp_valid && p1_rsp_ready) begin
        if (sb_q1.size() == 0) chk("p1_rsp_unexpected", 32'd1, 32'd0);
        else chk("p1_rsp_data", p1_rsp_rdata, sb_q1.pop_front());
      end
      if (p0_req_valid && p0_req_ready) begin
        if (p0_req_write) exp_mem[int'(p0_req_addr)] = merge(ref_rd(p0_req_addr), p0_req_wdata, p0_req_be);
        else sb_q0.push_back(ref_rd(p0_req_addr));
      end
      if (p1_req_valid && p1_req_ready) begin
        if (p1_req_write) exp_mem[int'(p1_req_addr)] = merge(ref_rd(p1_req_addr), p1_req_wdata, p1_req_be);
        else sb_q1.push_back(ref_rd(p1_req_addr));
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic w, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      p0_req_valid = v; p0_req_write = w; p0_req_addr = a; p0_req_be = be; p0_req_wdata = d;
    end else begin
      p1_req_valid = v; p1_req_write = w; p1_req_addr = a; p1_req_be = be; p1_req_wdata = d;
    end
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? p0_req_ready : p1_req_ready;
  endfunction

  // Called just after a posedge; returns just after the posedge following acceptance.
  task automatic do_wr(input int p, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    int n = 0;
    logic [3:0] nbe = ~be;
    set_req(p, 1'b1, 1'b1, a, be, d);
    @(negedge clk);
    while (!ready_of(p) && n < 20) begin @(negedge clk); n++; end
    chk("wr_accept", 32'(ready_of(p)), 32'd1);
    chk("wr_cen", 32'(sram_cen), 32'd0);
    chk("wr_gwen", 32'(sram_gwen), 32'd0);
    chk("wr_ben", 32'(sram_ben), 32'(nbe));
    chk("wr_addr", 32'(sram_a), 32'(a));
    chk("wr_data", sram_d, d);
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_rd(input int p, input logic [12:0] a);
    int n = 0;
    set_req(p, 1'b1, 1'b0, a, '0, '0);
    @(negedge clk);
    while (!ready_of(p) && n < 20) begin @(negedge clk); n++; end
    chk("rd_accept", 32'(ready_of(p)), 32'd1);
    chk("rd_cen", 32'(sram_cen), 32'd0);
    chk("rd_gwen", 32'(sram_gwen), 32'd1);
    chk("rd_ben", 32'(sram_ben), 32'(BEN_IDLE));
    chk("rd_addr", 32'(sram_a), 32'(a));
    @(posedge clk); #1;
    set_req(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    int n;
    logic [1:0] exp_gnt;
    rstn = 1'b0;
    p0_rsp_ready = 1'b1;
    p1_rsp_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 13'h0, '0, '0);
    set_req(1, 1'b1, 1'b0, 13'h0, '0, '0);

    // Reset held with both requesters asserting VALID.
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", 32'({p1_req_ready, p0_req_ready}), 32'd0);
      chk("rst_cen", 32'(sram_cen), 32'd1);
      chk("rst_ben", 32'(sram_ben), 32'hF);
      chk("rst_rsp_valid", 32'({p1_rsp_valid, p0_rsp_valid}), 32'd0);
      chk("rst_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'd0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    rstn = 1'b1;

    // Preload through the front door.
    for (int i = 0; i < 8; i++) do_wr(0, 13'(i), 4'hF, 32'h1000_0000 + 32'(i));
    do_wr(1, 13'h0010, 4'hF, 32'h1122_3344);
    do_wr(0, 13'h1FFF, 4'hF, 32'hDEAD_BEEF);
    do_wr(1, 13'h0020, 4'hF, 32'hCAFE_0001);

    // Idle macro drive.
    @(negedge clk);
    chk("idle_cen", 32'(sram_cen), 32'd1);
    chk("idle_gwen", 32'(sram_gwen), 32'd1);
    chk("idle_ben", 32'(sram_ben), 32'hF);
    chk("idle_addr", 32'(sram_a), 32'd0);
    chk("idle_data", sram_d, 32'd0);
    @(posedge clk); #1;

    // Partial byte write, then read back with one-cycle latency.
    do_wr(1, 13'h0010, 4'b0101, 32'hAABB_CCDD);
    do_rd(1, 13'h0010);
    @(negedge clk);
    chk("byte_rsp_valid", 32'(p1_rsp_valid), 32'd1);
    chk("byte_rsp_data", p1_rsp_rdata, 32'h11BB_33DD);
    @(posedge clk); #1;

    // BE=0 write leaves memory untouched.
    do_wr(0, 13'h0020, 4'h0, 32'hFFFF_FFFF);
    do_rd(0, 13'h0020);
    repeat (2) begin @(posedge clk); #1; end

    // Response back-pressure on port 0.
    p0_rsp_ready = 1'b0;
    do_rd(0, 13'h1FFF);
    set_req(0, 1'b1, 1'b1, 13'h0030, 4'hF, 32'h0000_5555);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(p0_rsp_valid), 32'd1);
      chk("bp_rsp_data", p0_rsp_rdata, 32'hDEAD_BEEF);
      if (k == 0) chk("bp_write_ready", 32'(p0_req_ready), 32'd1);
      else        chk("bp_read_ready", 32'(p0_req_ready), 32'd0);
      @(posedge clk); #1;
      if (k == 0) set_req(0, 1'b1, 1'b0, 13'h0001, '0, '0);
    end
    p0_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_valid", 32'(p0_rsp_valid), 32'd1);
    chk("bp_drain_data", p0_rsp_rdata, 32'hDEAD_BEEF);
    n = 0;
    while (!p0_req_ready && n < 20) begin @(negedge clk); n++; end
    chk("bp_read_accept", 32'(p0_req_ready), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) begin @(posedge clk); #1; end

    // Back-to-back streaming reads on port 0.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) set_req(0, 1'b1, 1'b0, 13'(i), '0, '0);
      else       set_req(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      if (i < 8) chk("stream_ready", 32'(p0_req_ready), 32'd1);
      if (i > 0) chk("stream_rsp_valid", 32'(p0_rsp_valid), 32'd1);
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end

    // Contention from a fresh reset so the pointer starts at port 0.
    rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rstn = 1'b1;
    set_req(0, 1'b1, 1'b0, 13'h0002, '0, '0);
    set_req(1, 1'b1, 1'b0, 13'h0003, '0, '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef SRAM_ARB_RR_EN
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b10;
`endif
      chk("contention_grant", 32'({p1_req_ready, p0_req_ready}), 32'(exp_gnt));
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) begin @(posedge clk); #1; end

    // Reset the cycle after a read is accepted: the response is discarded.
    do_rd(1, 13'h0020);
    rstn = 1'b0;
    sb_q1.delete();
    @(negedge clk);
    chk("rstmid_rsp_valid", 32'(p1_rsp_valid), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_stale", 32'(p1_rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    chk("sb0_empty", 32'(sb_q0.size()), 32'd0);
    chk("sb1_empty", 32'(sb_q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
